config_loop_seq: RTL

- Parametrised successor to the CSM configuration-loop controller. Repeatedly runs the JTAG stress loop (optional TRST pulse, then TDC chain config, then ASD chain config).
- Adds a programmable iteration count, per-target timeout, stop-on-fail and N-chain failure statistics.
- Sits between the slow-control VIO/register bank and the TDC/ASD JTAG config masters. All statistics leave on ports; no embedded VIO.

---
 rtl/config_loop_seq_if.sv | 29 ++
 rtl/config_loop_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/config_loop_seq_if.sv
// rtl/config_loop_seq_if.sv - request/done handshake between the loop sequencer and the JTAG config masters
interface config_loop_seq_if #(
  parameter int N_CHAIN = 6
);
  logic               tdc_loop_start;
  logic               asd_loop_start;
  logic               loop_trst;
  logic               tdc_config_done;
  logic               asd_config_done;
  logic [N_CHAIN-1:0] chain_success;

  modport master (
    output tdc_loop_start,
    output asd_loop_start,
    output loop_trst,
    input  tdc_config_done,
    input  asd_config_done,
    input  chain_success
  );

  modport slave (
    input  tdc_loop_start,
    input  asd_loop_start,
    input  loop_trst,
    output tdc_config_done,
    output asd_config_done,
    output chain_success
  );
endinterface

// File: rtl/config_loop_seq.sv
// rtl/config_loop_seq.sv - JTAG stress-loop sequencer (TRST / TDC / ASD) with iteration, timeout and failure statistics
module config_loop_seq #(
  parameter int                 N_CHAIN        = 6,
  parameter logic [N_CHAIN-1:0] TDC_CHAIN_MASK = 6'b111110,
  parameter int                 CNT_W          = 32,
  parameter int                 TRST_W         = 8,
  parameter int                 TO_W           = 24
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_loop_start,
  input  logic                     i_trst_en,
  input  logic                     i_tdc_en,
  input  logic                     i_asd_en,
  input  logic [TRST_W-1:0]        i_trst_interval,
  input  logic [CNT_W-1:0]         i_loop_count,
  input  logic                     i_stop_on_fail,
  input  logic [TO_W-1:0]          i_timeout_cycles,
  config_loop_seq_if.master        jtag,
  output logic                     o_busy,
  output logic                     o_halted,
  output logic [1:0]               o_halt_cause,
  output logic [CNT_W-1:0]         o_iter_count,
  output logic [CNT_W-1:0]         o_tdc_done_count,
  output logic [CNT_W-1:0]         o_asd_done_count,
  output logic [N_CHAIN*CNT_W-1:0] o_fail_count,
  output logic [CNT_W-1:0]         o_timeout_count
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRST,
    ST_TDC,
    ST_ASD,
    ST_NEXT,
    ST_STOP
  } state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_FAIL    = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
  localparam logic [1:0] CAUSE_COUNT   = 2'b11;

  state_t              r_state;
  logic                r_loop_start_d;
  logic [TRST_W-1:0]   r_dwell;
  logic [TO_W-1:0]     r_to;
  logic                r_tdc_req;
  logic                r_asd_req;
  logic                r_trst_n;
  logic                r_busy;
  logic                r_halted;
  logic [1:0]          r_halt_cause;
  logic [CNT_W-1:0]    r_iter_cnt;
  logic [CNT_W-1:0]    r_tdc_cnt;
  logic [CNT_W-1:0]    r_asd_cnt;
  logic [CNT_W-1:0]    r_to_cnt;
  logic [CNT_W-1:0]    r_fail_cnt [N_CHAIN];

  logic                w_start_edge;
  state_t              w_first_phase;
  state_t              w_after_trst;
  logic                w_tdc_acc;
  logic                w_asd_acc;
  logic                w_in_wait;
  logic [N_CHAIN-1:0]  w_fails;
  logic                w_fail_stop;
  logic                w_timeout;
  logic [CNT_W-1:0]    w_iter_inc;
  state_t              w_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    w_start_edge = i_loop_start & ~r_loop_start_d;

    w_first_phase = ST_IDLE;
    if (i_trst_en)     w_first_phase = ST_TRST;
    else if (i_tdc_en) w_first_phase = ST_TDC;
    else if (i_asd_en) w_first_phase = ST_ASD;

    w_after_trst = ST_NEXT;
    if (i_tdc_en)      w_after_trst = ST_TDC;
    else if (i_asd_en) w_after_trst = ST_ASD;

    // Done pulses outside the matching phase are dropped on the floor.
    w_tdc_acc = (r_state == ST_TDC) & jtag.tdc_config_done;
    w_asd_acc = (r_state == ST_ASD) & jtag.asd_config_done;
    w_in_wait = (r_state == ST_TDC) || (r_state == ST_ASD);

    w_fails = '0;
    if (w_tdc_acc)      w_fails = ~jtag.chain_success & TDC_CHAIN_MASK;
    else if (w_asd_acc) w_fails = ~jtag.chain_success & ~TDC_CHAIN_MASK;
    w_fail_stop = i_stop_on_fail & (|w_fails);

    w_timeout = w_in_wait & ~w_tdc_acc & ~w_asd_acc &
                (i_timeout_cycles != '0) & (r_to == i_timeout_cycles);

    w_iter_inc = sat_inc(r_iter_cnt);

    w_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start_edge) w_nxt = w_first_phase;
      ST_TRST: if (r_dwell == i_trst_interval) w_nxt = w_after_trst;
      ST_TDC: begin
        if (w_tdc_acc) begin
          if (w_fail_stop)   w_nxt = ST_STOP;
          else if (i_asd_en) w_nxt = ST_ASD;
          else               w_nxt = ST_NEXT;
        end else if (w_timeout) begin
          w_nxt = ST_STOP;
        end
      end
      ST_ASD: begin
        if (w_asd_acc)      w_nxt = w_fail_stop ? ST_STOP : ST_NEXT;
        else if (w_timeout) w_nxt = ST_STOP;
      end
      ST_NEXT: begin
        if ((i_loop_count != '0) && (w_iter_inc == i_loop_count)) w_nxt = ST_STOP;
        else if (i_loop_start)                                    w_nxt = w_first_phase;
        else                                                      w_nxt = ST_IDLE;
      end
      ST_STOP: if (!i_loop_start) w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= ST_IDLE;
      // Treat loop_start as already high so a level held across reset release is not an edge.
      r_loop_start_d <= 1'b1;
      r_dwell        <= '0;
      r_to           <= '0;
      r_tdc_req      <= 1'b0;
      r_asd_req      <= 1'b0;
      r_trst_n       <= 1'b1;
      r_busy         <= 1'b0;
      r_halted       <= 1'b0;
      r_halt_cause   <= CAUSE_NONE;
      r_iter_cnt     <= '0;
      r_tdc_cnt      <= '0;
      r_asd_cnt      <= '0;
      r_to_cnt       <= '0;
      for (int i = 0; i < N_CHAIN; i++) r_fail_cnt[i] <= '0;
    end else begin
      r_loop_start_d <= i_loop_start;
      r_state        <= w_nxt;
      r_busy         <= (w_nxt != ST_IDLE);
      r_tdc_req      <= (r_state == ST_TDC);
      r_asd_req      <= (r_state == ST_ASD);
      r_trst_n       <= !((w_nxt == ST_TRST) && (r_state != ST_TRST));
      r_dwell        <= ((r_state == ST_TRST) && (w_nxt == ST_TRST)) ? r_dwell + TRST_W'(1) : '0;

      // Phase timer restarts on every entry into TDC/ASD and parks at all-ones.
      if (w_in_wait && (w_nxt == r_state))
        r_to <= (&r_to) ? r_to : r_to + TO_W'(1);
      else
        r_to <= '0;

      if ((r_state == ST_IDLE) && w_start_edge) begin
        r_halted     <= 1'b0;
        r_halt_cause <= CAUSE_NONE;
        r_iter_cnt   <= '0;
        r_tdc_cnt    <= '0;
        r_asd_cnt    <= '0;
        r_to_cnt     <= '0;
        for (int i = 0; i < N_CHAIN; i++) r_fail_cnt[i] <= '0;
      end else begin
        if (w_tdc_acc) r_tdc_cnt <= sat_inc(r_tdc_cnt);
        if (w_asd_acc) r_asd_cnt <= sat_inc(r_asd_cnt);
        for (int i = 0; i < N_CHAIN; i++) begin
          if (w_fails[i]) r_fail_cnt[i] <= sat_inc(r_fail_cnt[i]);
        end
        if ((w_tdc_acc || w_asd_acc) && w_fail_stop) begin
          r_halted     <= 1'b1;
          r_halt_cause <= CAUSE_FAIL;
        end
        if (w_timeout) begin
          r_to_cnt     <= sat_inc(r_to_cnt);
          r_halted     <= 1'b1;
          r_halt_cause <= CAUSE_TIMEOUT;
        end
        if (r_state == ST_NEXT) begin
          r_iter_cnt <= w_iter_inc;
          if (w_nxt == ST_STOP) r_halt_cause <= CAUSE_COUNT;
        end
      end
    end
  end

  assign jtag.tdc_loop_start = r_tdc_req;
  assign jtag.asd_loop_start = r_asd_req;
  assign jtag.loop_trst      = r_trst_n;

  assign o_busy           = r_busy;
  assign o_halted         = r_halted;
  assign o_halt_cause     = r_halt_cause;
  assign o_iter_count     = r_iter_cnt;
  assign o_tdc_done_count = r_tdc_cnt;
  assign o_asd_done_count = r_asd_cnt;
  assign o_timeout_count  = r_to_cnt;

  for (genvar g = 0; g < N_CHAIN; g++) begin : g_fail_out
    assign o_fail_count[g*CNT_W +: CNT_W] = r_fail_cnt[g];
  end

endmodule
